// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code receive checker and its decoder.
package gray_pkg;

    localparam int GRAY_WIDTH  = 3;
    localparam int GRAY_WRAP_W = 4;
    localparam int GRAY_ERR_W  = 8;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SYNC     = 2'd1,
        LOCKED   = 2'd2
    } gchk_state_t;

endpackage

// File: rtl/gray_check_gray2bin.sv
// Purely combinational Gray-to-binary decoder, reusable by any Gray consumer.
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary
);

    // Each binary bit is the running XOR of all Gray bits from the MSB down.
    always_comb begin
        logic acc;
        binary = '0;
        acc    = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc       = acc ^ gray[i];
            binary[i] = acc;
        end
    end

endmodule

// File: rtl/gray_check.sv
// Receive-side Gray count monitor: tracks lock, counts wraps and illegal steps.
module gray_check
    import gray_pkg::*;
#(
    parameter int WIDTH  = GRAY_WIDTH,
    parameter int WRAP_W = GRAY_WRAP_W,
    parameter int ERR_W  = GRAY_ERR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic [WIDTH-1:0]  Gray,
    output logic [WIDTH-1:0]  Binary,
    output logic              Locked,
    output logic              Overflow,
    output logic              Error,
    output logic [WRAP_W-1:0] WrapCnt,
    output logic [ERR_W-1:0]  ErrCnt
);

    localparam logic [WIDTH-1:0] MAX_CODE = '1;

    gchk_state_t      state, state_next;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] prev, prev_next;
    logic [WIDTH-1:0] nxt;
    logic             wrap_hit;
    logic             err_hit;

    gray2bin #(.WIDTH(WIDTH)) u_dec (
        .gray   (Gray),
        .binary (sample)
    );

    assign nxt = prev + 1'b1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    // A sample equal to prev is a legal stall; only a non-stall, non-advance step is an error.
    always_comb begin
        state_next = state;
        prev_next  = prev;
        wrap_hit   = 1'b0;
        err_hit    = 1'b0;
        if (En) begin
            case (state)
                UNLOCKED: begin
                    prev_next  = sample;
                    state_next = SYNC;
                end
                SYNC: begin
                    prev_next = sample;
                    if (sample == nxt) begin
                        state_next = LOCKED;
                        wrap_hit   = (prev == MAX_CODE);
                    end
                end
                LOCKED: begin
                    if (sample == nxt) begin
                        prev_next = sample;
                        wrap_hit  = (prev == MAX_CODE);
                    end else if (sample != prev) begin
                        err_hit    = 1'b1;
                        prev_next  = sample;
                        state_next = SYNC;
                    end
                end
                default: begin
                    state_next = UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev     <= '0;
            Binary   <= '0;
            Overflow <= 1'b0;
            Error    <= 1'b0;
            WrapCnt  <= '0;
            ErrCnt   <= '0;
        end else begin
            prev     <= prev_next;
            Overflow <= wrap_hit;
            Error    <= err_hit;
            if (En) begin
                Binary <= sample;
            end
            if (wrap_hit) begin
                WrapCnt <= WrapCnt + 1'b1;
            end
            if (err_hit && (ErrCnt != '1)) begin
                ErrCnt <= ErrCnt + 1'b1;
            end
        end
    end

    assign Locked = (state == LOCKED);

endmodule

// File: tb/tb_gray_check.sv
// Directed, table-driven bench for gray_check with hand-computed expectations.
module tb_gray_check;

    logic       Clk;
    logic       Reset;
    logic       En;
    logic [2:0] Gray;
    logic [2:0] Binary;
    logic       Locked;
    logic       Overflow;
    logic       Error;
    logic [3:0] WrapCnt;
    logic [7:0] ErrCnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] gray;
        logic [2:0] bin;
        logic       locked;
        logic       ovf;
        logic       err;
        logic [3:0] wrap;
        logic [7:0] errc;
    } vec_t;

    vec_t tableA[$];
    vec_t tableB[$];

    gray_check #(.WIDTH(3), .WRAP_W(4), .ERR_W(8)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .Gray     (Gray),
        .Binary   (Binary),
        .Locked   (Locked),
        .Overflow (Overflow),
        .Error    (Error),
        .WrapCnt  (WrapCnt),
        .ErrCnt   (ErrCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Inputs change just after a rising edge, so they are stable well before the next one.
    task automatic applyStimulus(input logic rst, input logic en, input logic [2:0] g);
        Reset = rst;
        En    = en;
        Gray  = g;
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOne(input string tag, input string field, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s %s: got %0h expected %0h", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] bin, input logic locked,
                               input logic ovf, input logic err, input logic [3:0] wrap,
                               input logic [7:0] errc);
        checkOne(tag, "Binary",   {5'd0, Binary},   {5'd0, bin});
        checkOne(tag, "Locked",   {7'd0, Locked},   {7'd0, locked});
        checkOne(tag, "Overflow", {7'd0, Overflow}, {7'd0, ovf});
        checkOne(tag, "Error",    {7'd0, Error},    {7'd0, err});
        checkOne(tag, "WrapCnt",  {4'd0, WrapCnt},  {4'd0, wrap});
        checkOne(tag, "ErrCnt",   ErrCnt,           errc);
    endtask

    task automatic runTable(input string name, input vec_t tbl[$]);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].gray);
            checkOutput($sformatf("%s[%0d]", name, i), tbl[i].bin, tbl[i].locked,
                        tbl[i].ovf, tbl[i].err, tbl[i].wrap, tbl[i].errc);
        end
    endtask

    initial begin
        Reset = 1'b1;
        En    = 1'b0;
        Gray  = 3'b000;

        // rst en gray  | bin locked ovf err wrap errc
        tableA.push_back('{1'b1, 1'b1, 3'b101, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b001, 3'd1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b010, 3'd3, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b110, 3'd4, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b111, 3'd5, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b101, 3'd6, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b100, 3'd7, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b000, 3'd0, 1'b1, 1'b1, 1'b0, 4'd1, 8'd0});
        tableA.push_back('{1'b0, 1'b0, 3'b111, 3'd0, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b001, 3'd1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0});
        tableA.push_back('{1'b0, 1'b1, 3'b110, 3'd4, 1'b0, 1'b0, 1'b1, 4'd1, 8'd1});
        tableA.push_back('{1'b0, 1'b1, 3'b111, 3'd5, 1'b1, 1'b0, 1'b0, 4'd1, 8'd1});

        tableB.push_back('{1'b1, 1'b1, 3'b110, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0});
        tableB.push_back('{1'b0, 1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0});
        tableB.push_back('{1'b0, 1'b1, 3'b011, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0});
        tableB.push_back('{1'b0, 1'b1, 3'b011, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0});
        tableB.push_back('{1'b0, 1'b1, 3'b010, 3'd3, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
        tableB.push_back('{1'b0, 1'b1, 3'b100, 3'd7, 1'b0, 1'b0, 1'b1, 4'd0, 8'd1});
        tableB.push_back('{1'b0, 1'b1, 3'b000, 3'd0, 1'b1, 1'b1, 1'b0, 4'd1, 8'd1});
        tableB.push_back('{1'b1, 1'b0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0});
        tableB.push_back('{1'b0, 1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0});
        tableB.push_back('{1'b0, 1'b1, 3'b001, 3'd1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0});

        @(posedge Clk);
        #1;
        runTable("stream", tableA);

        // Enable low: random codes must not disturb anything, and no pulses appear.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 3'($urandom_range(0, 7)));
            checkOutput($sformatf("gate[%0d]", i), 3'd5, 1'b1, 1'b0, 1'b0, 4'd1, 8'd1);
        end

        runTable("resync", tableB);

        // Each 001,011,000 triplet relocks, advances, then takes one illegal step.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b1, 3'b001);
            applyStimulus(1'b0, 1'b1, 3'b011);
            applyStimulus(1'b0, 1'b1, 3'b000);
            checkOne($sformatf("sat[%0d]", i), "Error",  {7'd0, Error},  8'd1);
            checkOne($sformatf("sat[%0d]", i), "ErrCnt", ErrCnt, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
            checkOne($sformatf("sat[%0d]", i), "Locked", {7'd0, Locked}, 8'd0);
        end
        applyStimulus(1'b0, 1'b0, 3'b000);
        checkOutput("sat_end", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_check.md
# gray_check

Receive-side companion to the `gray` counter: samples a Gray-coded count bus each enabled cycle, decodes it to binary and checks that the producer only ever holds or advances by exactly one code. It reports lock status, wrap-around events and step errors, with saturating and wrapping counters. It sits on the consumer side of any Gray-coded count crossing, for example a pointer or position bus, and is also used as a bench monitor.

## Interface
- `WIDTH`, 3: Gray/binary bus width (≥2).
- `WRAP_W`, 4: width of wrap counter.
- `ERR_W`, 8: width of error counter.

- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high; overrides all other inputs.
- `En` in 1: sample strobe. `Gray` is considered only when `En`=1.
- `Gray` in WIDTH: Gray-coded input.
- `Binary` out WIDTH: decoded value of the last accepted sample.
- `Locked` out 1: high while the tracked sequence is valid.
- `Overflow` out 1: one-cycle pulse on wrap from binary 2^WIDTH−1 to 0.
- `Error` out 1: one-cycle pulse on an illegal step while locked.
- `WrapCnt` out WRAP_W: number of wraps, modulo 2^WRAP_W.
- `ErrCnt` out ERR_W: number of errors, saturating at 2^ERR_W−1.

## Operation
- Decode: b[W−1]=g[W−1]; b[i]=b[i+1]^g[i]. `prev` holds the last accepted binary value. "Next" means (prev+1) mod 2^WIDTH.
- FSM states are UNLOCKED, SYNC and LOCKED. Reset places the FSM in UNLOCKED.
- UNLOCKED, on `En`: capture sample into `prev`, then go to SYNC.
- SYNC, on `En`:
  - sample == next: go to LOCKED.
  - Otherwise: recapture and stay in SYNC.
  - A sample equal to `prev` stays in SYNC with no error.
- LOCKED, on `En`:
  - sample == prev: stall, no change.
  - sample == next: advance.
  - Any other value: pulse `Error`, increment `ErrCnt` (saturating), capture sample and go to SYNC.
- Wrap: an accepted advance with prev = 2^WIDTH−1 and sample = 0 pulses `Overflow` and increments `WrapCnt`. This applies to the SYNC→LOCKED transition as well as to advances in LOCKED.
- `En`=0: FSM, `prev` and counters hold. `Overflow` and `Error` go to 0.
- Width rules:
  - Counters wrap only at their own width; `ErrCnt` never wraps.
  - All comparisons are in binary at WIDTH bits; the +1 is modulo 2^WIDTH.

## Timing
- All outputs are registered. The response to the sample presented at edge k appears after edge k, i.e. latency 1.
- `Binary` updates on every `En` sample in every state, including erroneous samples.
- `Locked` = (state==LOCKED), registered.
- Reset values: `Binary`=0, `Locked`=0, `Overflow`=0, `Error`=0, `WrapCnt`=0, `ErrCnt`=0, state UNLOCKED.
- `Reset` and `En` in the same cycle: `Reset` wins, and the sample is discarded.
- Reset mid-sequence: all state clears; re-lock requires two consecutive legal samples.
- A producer reset to 0 from a non-terminal code appears as an illegal step. The block reports `Error` once, then re-locks on 0→1.
- `Overflow` and `Error` are never high in the same cycle.

## Structure
- Shared package `gray_pkg` holds:
  - the state enum `gchk_state_t` (UNLOCKED, SYNC, LOCKED);
  - the default width constants.
- Sub-module `gray2bin`: purely combinational decoder, parameterised by WIDTH. It is reusable by other Gray consumers.
- Top level: FSM, `prev` register, two counters and output registers.

## Test plan
- **Clean stream.** After Reset, hold `En`=1 and apply 000,001,011,010,110,111,101,100,000.
  - `Binary` follows 0..7 then 0.
  - `Locked` rises one cycle after the 001 sample.
  - `Overflow` pulses once after the final 000 sample, and `WrapCnt`=1.
  - `Error` stays 0.
- **Stall.** While locked at 011, apply 011 three times → `Locked`=1, `Binary`=2, no `Error`.
- **Skip.** Locked at 011, apply 110.
  - `Error` pulses once, `ErrCnt`=1, `Locked`=0, `Binary`=4.
  - Then apply 111 → `Locked`=1.
- **Gating.** With `En`=0, apply random `Gray` for 10 cycles → all outputs unchanged, no pulses.
- **Reset mid-stream.** Assert `Reset` with `En`=1 at binary 5 → next cycle all outputs 0 and state UNLOCKED. Applying 000 then 001 re-locks.
- **Saturation.** With `ERR_W`=8, apply 300 locked-then-illegal pairs (001,011,000 repeated) → `ErrCnt` stops at 255 and `Error` still pulses each time.
